// File: rtl/mdio_slave.sv
// Purpose : MDIO responder (PHY/MMD side) that decodes Clause 22 and Clause 45 frames
//           and turns them into local register read/write strobes.
// Latency : strobes fire on the clk_core cycle after the MDC-rising tick that completes
//           the field, plus 2-3 clk_core of MDC/MDIO synchronisation.
// Backpr. : none. Local register logic must take o_wr_en in one cycle and return
//           i_rd_data on the cycle after o_rd_req. The MDC pace sets all frame timing.
// Ports   : clk_core/sReset_n     core clock (>= 8x MDC), synchronous active-low reset
//           i_mdc/i_mdio          asynchronous pad inputs, 2-flop synchronised here
//           o_mdio/o_mdio_oe      pad output value and enable (1 = drive)
//           o_cl45/o_devad        clause and REGAD/DEVAD of the current/last frame
//           o_reg_addr            CL22 {11'b0,REGAD}; CL45 stored address register
//           o_rd_req/i_rd_data    read strobe; data sampled on the following cycle
//           o_wr_en/o_wr_data     write strobe with data
//           o_frame_err           pulse on a write/address frame with TA != 10
module mdio_slave #(
  parameter logic [4:0] PHY_ADDR     = 5'h01,
  parameter int         PREAMBLE_LEN = 32,
  parameter bit         CL45_EN      = 1'b1
) (
  input  logic        clk_core,
  input  logic        sReset_n,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic        o_cl45,
  output logic [4:0]  o_devad,
  output logic [15:0] o_reg_addr,
  output logic        o_rd_req,
  input  logic [15:0] i_rd_data,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_frame_err
);

  localparam logic [5:0] PRE_MIN    = 6'(PREAMBLE_LEN);
  localparam logic [5:0] PRE_SAT    = 6'd63;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP45_RDINC = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST2,
    S_OP,
    S_PHY,
    S_REG,
    S_SKIP,
    S_RD_TA,
    S_RD_DAT,
    S_WR_TA,
    S_WR_DAT
  } state_t;

  state_t      state;

  logic        mdc_s1;
  logic        mdc_s2;
  logic        mdc_prev;
  logic        mdio_s1;
  logic        mdio_s2;

  logic        tick;
  logic        bit_in;

  logic [5:0]  pre_cnt;
  logic [4:0]  cnt;
  logic        cl45_cur;
  logic [1:0]  op;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic [15:0] addr45;
  logic        ta_first;

  logic [1:0]  op_nxt;
  logic [4:0]  regad_nxt;
  logic [15:0] sh_in;
  logic        op_is_read;

  // MDC rising edge as seen after synchronisation; MDIO is sampled on this tick.
  assign tick      = mdc_s2 & ~mdc_prev;
  assign bit_in    = mdio_s2;
  assign op_nxt    = {op[0], bit_in};
  assign regad_nxt = {regad[3:0], bit_in};
  assign sh_in     = {shreg[14:0], bit_in};
  // CL22 read is 10, CL45 read/read-increment are 11/10; invalid CL22 ops never get
  // this far, so the op MSB alone identifies a read in both clauses.
  assign op_is_read = op[1];

  always_ff @(posedge clk_core) begin
    if (!sReset_n) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_s1  <= 1'b1;
      mdio_s2  <= 1'b1;
    end else begin
      mdc_s1   <= i_mdc;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= i_mdio;
      mdio_s2  <= mdio_s1;
    end
  end

  always_ff @(posedge clk_core) begin
    if (!sReset_n) begin
      state       <= S_IDLE;
      pre_cnt     <= '0;
      cnt         <= '0;
      cl45_cur    <= 1'b0;
      op          <= '0;
      phyad       <= '0;
      regad       <= '0;
      shreg       <= '0;
      addr45      <= '0;
      ta_first    <= 1'b0;
      o_mdio      <= 1'b1;
      o_mdio_oe   <= 1'b0;
      o_cl45      <= 1'b0;
      o_devad     <= '0;
      o_reg_addr  <= '0;
      o_rd_req    <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_rd_req    <= 1'b0;
      o_wr_en     <= 1'b0;
      o_frame_err <= 1'b0;

      // Read data arrives the cycle after the request. Ticks are at least one MDC
      // period apart, so this load never collides with a tick-driven shift.
      if (o_rd_req) begin
        shreg <= i_rd_data;
      end

      if (tick) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PRE_SAT) begin
                pre_cnt <= pre_cnt + 6'd1;
              end
            end else begin
              // A 0 is either the first ST bit after a full preamble or noise.
              pre_cnt <= '0;
              if (pre_cnt >= PRE_MIN) begin
                state <= S_ST2;
              end
            end
          end

          S_ST2: begin
            if (bit_in) begin
              cl45_cur <= 1'b0;
              cnt      <= 5'd1;
              state    <= S_OP;
            end else if (CL45_EN) begin
              cl45_cur <= 1'b1;
              cnt      <= 5'd1;
              state    <= S_OP;
            end else begin
              state <= S_IDLE;
            end
          end

          S_OP: begin
            op <= op_nxt;
            if (cnt == 5'd0) begin
              if (!cl45_cur && (op_nxt == 2'b00 || op_nxt == 2'b11)) begin
                state <= S_IDLE;
              end else begin
                cnt   <= 5'd4;
                state <= S_PHY;
              end
            end else begin
              cnt <= cnt - 5'd1;
            end
          end

          S_PHY: begin
            phyad <= {phyad[3:0], bit_in};
            if (cnt == 5'd0) begin
              cnt   <= 5'd4;
              state <= S_REG;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end

          S_REG: begin
            regad <= regad_nxt;
            if (cnt == 5'd0) begin
              o_devad    <= regad_nxt;
              o_cl45     <= cl45_cur;
              o_reg_addr <= cl45_cur ? addr45 : {11'b0, regad_nxt};
              if (phyad != PHY_ADDR) begin
                // Let TA plus 16 data bits pass without touching the bus.
                cnt   <= 5'd17;
                state <= S_SKIP;
              end else if (op_is_read) begin
                o_rd_req <= 1'b1;
                state    <= S_RD_TA;
              end else begin
                cnt   <= 5'd1;
                state <= S_WR_TA;
              end
            end else begin
              cnt <= cnt - 5'd1;
            end
          end

          S_SKIP: begin
            if (cnt == 5'd0) begin
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end

          S_RD_TA: begin
            // Starting to drive after the TA1 edge leaves TA1 undriven and TA2 at 0.
            o_mdio_oe <= 1'b1;
            o_mdio    <= 1'b0;
            cnt       <= 5'd16;
            state     <= S_RD_DAT;
          end

          S_RD_DAT: begin
            if (cnt == 5'd0) begin
              // D0 has been on the bus for a full MDC period: release.
              o_mdio_oe <= 1'b0;
              o_mdio    <= 1'b1;
              state     <= S_IDLE;
              if (cl45_cur && op == OP45_RDINC) begin
                addr45     <= addr45 + 16'd1;
                o_reg_addr <= addr45 + 16'd1;
              end
            end else begin
              o_mdio <= shreg[15];
              shreg  <= {shreg[14:0], 1'b0};
              cnt    <= cnt - 5'd1;
            end
          end

          S_WR_TA: begin
            if (cnt != 5'd0) begin
              ta_first <= bit_in;
              cnt      <= 5'd0;
            end else if ({ta_first, bit_in} == 2'b10) begin
              cnt   <= 5'd15;
              state <= S_WR_DAT;
            end else begin
              o_frame_err <= 1'b1;
              cnt         <= 5'd15;
              state       <= S_SKIP;
            end
          end

          S_WR_DAT: begin
            shreg <= sh_in;
            if (cnt == 5'd0) begin
              if (op == OP_WRITE) begin
                o_wr_data <= sh_in;
                o_wr_en   <= 1'b1;
              end else begin
                // CL45 address frame: load the stored address, no write strobe.
                addr45     <= sh_in;
                o_reg_addr <= sh_in;
              end
              state <= S_IDLE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
